// File: rtl/sparc_ffu_frf_arb_pkg.sv
// Shared FRF geometry and the write-buffer entry layout used by the
// arbiter and its write FIFO.
package sparc_ffu_frf_arb_pkg;

  localparam int FRF_AW   = 7;
  localparam int FRF_DW   = 78;
  localparam int FRF_HALF = 39;

  typedef struct packed {
    logic [FRF_AW-1:0] addr;
    logic [1:0]        wen;
    logic [FRF_DW-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/sparc_ffu_frf_wbuf.sv
// Write FIFO for the FRF arbiter: circular buffer with per-entry valid bits
// so the arbiter can detect read-after-write hazards against pending entries.
module sparc_ffu_frf_wbuf
  import sparc_ffu_frf_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  wr_entry_t                    push_entry,
  input  logic                         pop,
  input  logic [FRF_AW-1:0]            cmp_addr,
  output wr_entry_t                    head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [DEPTH-1:0]             hit
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wr_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;
  logic [DEPTH-1:0] w_vld_nxt;

  // Pointers wrap explicitly so non-power-of-two depths behave.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? PW'(0) : p + PW'(1);
  endfunction

  always_comb begin
    w_vld_nxt = '0;
    hit       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_vld_nxt[i] = (push && (r_wr_ptr == PW'(i))) ||
                     (r_vld[i] && !(pop && (r_rd_ptr == PW'(i))));
      hit[i]       = r_vld[i] && (r_mem[i].addr == cmp_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_vld    <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      if (push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (push && !pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (pop && !push) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_cnt == CW'(DEPTH));
  assign empty = (r_cnt == CW'(0));
  assign count = r_cnt;

endmodule

// File: rtl/sparc_ffu_frf_arb.sv
// FRF port arbiter: one operation per cycle, reads win unless they hit a
// pending write or the oldest write has been starved STARVE_LIMIT times.
module sparc_ffu_frf_arb
  import sparc_ffu_frf_arb_pkg::*;
#(
  parameter int WBUF_DEPTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              rclk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [FRF_AW-1:0] rd_addr,
  output logic              rd_rdy,
  output logic              rd_vld,
  output logic [FRF_DW-1:0] rd_data,
  input  logic              wr_req,
  input  logic [FRF_AW-1:0] wr_addr,
  input  logic [1:0]        wr_wen,
  input  logic [FRF_DW-1:0] wr_data,
  output logic              wr_rdy,
  output logic              frf_ren,
  output logic [1:0]        frf_wen,
  output logic [FRF_AW-1:0] frf_addr,
  output logic [FRF_DW-1:0] frf_wdata,
  input  logic [FRF_DW-1:0] frf_rdata,
  output logic [1:0]        wbuf_cnt
);

  localparam int CW = $clog2(WBUF_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wr_entry_t             w_head;
  wr_entry_t             w_push_entry;
  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_cnt;
  logic [WBUF_DEPTH-1:0] w_hit;
  logic                  w_push;
  logic                  w_rd_issue;
  logic                  w_drain;
  logic                  w_starved;
  logic [SW-1:0]         r_starve;
  logic [1:0]            r_rd_vld_pipe;
  logic [FRF_DW-1:0]     r_rd_data;

  assign w_push_entry = '{addr: wr_addr, wen: wr_wen, data: wr_data};

  sparc_ffu_frf_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk        (rclk),
    .reset      (reset),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_drain),
    .cmp_addr   (rd_addr),
    .head       (w_head),
    .full       (w_full),
    .empty      (w_empty),
    .count      (w_cnt),
    .hit        (w_hit)
  );

  // A same-cycle write is not in w_hit yet, so the read sees pre-write data.
  assign w_starved  = (r_starve == SW'(STARVE_LIMIT));
  assign rd_rdy     = !reset && !(|w_hit) && !w_starved;
  assign wr_rdy     = !reset && !w_full;
  assign w_rd_issue = rd_req && rd_rdy;
  assign w_drain    = !reset && !w_rd_issue && !w_empty;
  assign w_push     = wr_req && wr_rdy && (|wr_wen);

  always_comb begin
    frf_ren   = w_rd_issue;
    frf_wen   = 2'b00;
    frf_addr  = '0;
    frf_wdata = '0;
    if (w_rd_issue) begin
      frf_addr = rd_addr;
    end else if (w_drain) begin
      frf_wen   = w_head.wen;
      frf_addr  = w_head.addr;
      frf_wdata = w_head.data;
    end else begin
      frf_addr = '0;
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_drain) begin
      r_starve <= '0;
    end else if (!w_empty && w_rd_issue && !w_starved) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // Stage 0 marks the SRAM access cycle; frf_rdata is captured into the output flop then.
  always_ff @(posedge rclk) begin
    if (reset) begin
      r_rd_vld_pipe <= 2'b00;
      r_rd_data     <= '0;
    end else begin
      r_rd_vld_pipe <= {r_rd_vld_pipe[0], w_rd_issue};
      if (r_rd_vld_pipe[0]) begin
        r_rd_data <= frf_rdata;
      end
    end
  end

  assign rd_vld   = r_rd_vld_pipe[1] && !reset;
  assign rd_data  = r_rd_data;
  assign wbuf_cnt = reset ? 2'b00 : 2'(w_cnt);

endmodule

// File: tb/tb_sparc_ffu_frf_arb.sv
// Bench for sparc_ffu_frf_arb: directed scenarios, an FRF SRAM model, and a
// queue-based reference model compared against the DUT every cycle.
module tb_sparc_ffu_frf_arb;

  localparam int DEPTH  = 2;
  localparam int STARVE = 8;

  logic        rclk;
  logic        reset;
  logic        rd_req;
  logic [6:0]  rd_addr;
  logic        rd_rdy;
  logic        rd_vld;
  logic [77:0] rd_data;
  logic        wr_req;
  logic [6:0]  wr_addr;
  logic [1:0]  wr_wen;
  logic [77:0] wr_data;
  logic        wr_rdy;
  logic        frf_ren;
  logic [1:0]  frf_wen;
  logic [6:0]  frf_addr;
  logic [77:0] frf_wdata;
  logic [77:0] frf_rdata;
  logic [1:0]  wbuf_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  sparc_ffu_frf_arb #(.WBUF_DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
    .rclk(rclk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy), .rd_vld(rd_vld), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_wen(wr_wen), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .frf_ren(frf_ren), .frf_wen(frf_wen), .frf_addr(frf_addr), .frf_wdata(frf_wdata),
    .frf_rdata(frf_rdata), .wbuf_cnt(wbuf_cnt)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic chk(input string nm, input logic [77:0] act, input logic [77:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge rclk);
    #1;
  endtask

  // FRF SRAM: one-cycle read, half-masked writes.
  initial begin : sram_blk
    logic [77:0] sram [128];
    for (int i = 0; i < 128; i++) sram[i] = '0;
    forever begin
      @(posedge rclk);
      if (frf_ren) frf_rdata <= sram[frf_addr];
      if (frf_wen[1]) sram[frf_addr][77:39] <= frf_wdata[77:39];
      if (frf_wen[0]) sram[frf_addr][38:0]  <= frf_wdata[38:0];
    end
  end

  // Reference model: pending writes as a queue, register file as an array.
  initial begin : model_blk
    logic [6:0]  q_addr [$];
    logic [1:0]  q_wen  [$];
    logic [77:0] q_data [$];
    logic [77:0] gmem [128];
    bit          pv [2];
    logic [77:0] pd [2];
    int          starve;
    int          sz;
    bit          hz, e_rrdy, e_wrdy, iss, drn;
    logic [6:0]  e_addr;
    for (int i = 0; i < 128; i++) gmem[i] = '0;
    pv[0] = 0; pv[1] = 0; pd[0] = '0; pd[1] = '0; starve = 0;
    forever begin
      @(negedge rclk);
      sz = q_addr.size();
      if (reset) begin
        chk("m_rst_rd_rdy", 78'(rd_rdy), 78'(0));
        chk("m_rst_wr_rdy", 78'(wr_rdy), 78'(0));
        chk("m_rst_frf_ren", 78'(frf_ren), 78'(0));
        chk("m_rst_frf_wen", 78'(frf_wen), 78'(0));
        chk("m_rst_cnt", 78'(wbuf_cnt), 78'(0));
        chk("m_rst_rd_vld", 78'(rd_vld), 78'(0));
        q_addr.delete(); q_wen.delete(); q_data.delete();
        pv[0] = 0; pv[1] = 0; starve = 0;
      end else begin
        hz = 0;
        foreach (q_addr[i]) if (q_addr[i] == rd_addr) hz = 1;
        e_rrdy = !hz && (starve != STARVE);
        e_wrdy = (sz < DEPTH);
        iss    = rd_req && e_rrdy;
        drn    = !iss && (sz > 0);
        e_addr = iss ? rd_addr : (drn ? q_addr[0] : 7'd0);
        chk("m_rd_rdy", 78'(rd_rdy), 78'(e_rrdy));
        chk("m_wr_rdy", 78'(wr_rdy), 78'(e_wrdy));
        chk("m_frf_ren", 78'(frf_ren), 78'(iss));
        chk("m_frf_wen", 78'(frf_wen), 78'(drn ? q_wen[0] : 2'b00));
        chk("m_frf_addr", 78'(frf_addr), 78'(e_addr));
        chk("m_frf_wdata", frf_wdata, drn ? q_data[0] : 78'd0);
        chk("m_cnt", 78'(wbuf_cnt), 78'(sz));
        chk("m_rd_vld", 78'(rd_vld), 78'(pv[1]));
        if (pv[1]) chk("m_rd_data", rd_data, pd[1]);
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = iss;   pd[0] = iss ? gmem[rd_addr] : 78'd0;
        if (drn) begin
          if (q_wen[0][1]) gmem[q_addr[0]][77:39] = q_data[0][77:39];
          if (q_wen[0][0]) gmem[q_addr[0]][38:0]  = q_data[0][38:0];
          void'(q_addr.pop_front()); void'(q_wen.pop_front()); void'(q_data.pop_front());
          starve = 0;
        end else if (sz > 0 && iss && starve < STARVE) begin
          starve++;
        end
        if (wr_req && e_wrdy && wr_wen != 2'b00) begin
          q_addr.push_back(wr_addr); q_wen.push_back(wr_wen); q_data.push_back(wr_data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int  n;
    bit  seen;
    reset = 1'b1; rd_req = 1'b0; rd_addr = 7'd0;
    wr_req = 1'b0; wr_addr = 7'd0; wr_wen = 2'b00; wr_data = 78'd0;
    cyc(); cyc();
    @(negedge rclk);
    chk("rst_rd_rdy", 78'(rd_rdy), 78'(0));
    chk("rst_wr_rdy", 78'(wr_rdy), 78'(0));
    chk("rst_cnt", 78'(wbuf_cnt), 78'(0));
    cyc(); reset = 1'b0;
    @(negedge rclk);
    chk("post_rst_rd_rdy", 78'(rd_rdy), 78'(1));
    chk("post_rst_wr_rdy", 78'(wr_rdy), 78'(1));

    // Basic write then read
    cyc(); wr_req = 1'b1; wr_addr = 7'h05; wr_wen = 2'b11; wr_data = 78'h0_1234;
    cyc(); wr_req = 1'b0;
    cyc(); rd_req = 1'b1; rd_addr = 7'h05;
    cyc(); rd_req = 1'b0;
    cyc();
    @(negedge rclk);
    chk("basic_vld", 78'(rd_vld), 78'(1));
    chk("basic_data", rd_data, 78'h0_1234);

    // Hazard against a pending write
    cyc(); rd_req = 1'b1; rd_addr = 7'h33;
    wr_req = 1'b1; wr_addr = 7'h10; wr_wen = 2'b11; wr_data = 78'h3_CAFE_0000_BEEF;
    cyc(); wr_req = 1'b0; rd_addr = 7'h10;
    @(negedge rclk);
    chk("hazard_rd_rdy", 78'(rd_rdy), 78'(0));
    chk("hazard_drain_wen", 78'(frf_wen), 78'(2'b11));
    cyc();
    @(negedge rclk);
    chk("hazard_release", 78'(rd_rdy), 78'(1));
    cyc(); rd_req = 1'b0;
    cyc();
    @(negedge rclk);
    chk("hazard_vld", 78'(rd_vld), 78'(1));
    chk("hazard_data", rd_data, 78'h3_CAFE_0000_BEEF);

    // Starvation: one write, reads held continuously
    cyc(); rd_req = 1'b1; rd_addr = 7'h40;
    wr_req = 1'b1; wr_addr = 7'h41; wr_wen = 2'b11; wr_data = 78'h41;
    cyc(); wr_req = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge rclk);
      if (!rd_rdy) break;
      n++;
      cyc();
    end
    chk("starve_reads_won", 78'(n), 78'(8));
    chk("starve_drain_wen", 78'(frf_wen), 78'(2'b11));
    cyc();
    @(negedge rclk);
    chk("starve_rd_rdy_back", 78'(rd_rdy), 78'(1));

    // Full buffer under continuous reads
    cyc(); rd_addr = 7'h50;
    wr_req = 1'b1; wr_addr = 7'h51; wr_data = 78'h51;
    cyc(); wr_addr = 7'h52; wr_data = 78'h52;
    cyc(); wr_addr = 7'h53; wr_data = 78'h53;
    @(negedge rclk);
    chk("full_cnt", 78'(wbuf_cnt), 78'(2));
    chk("full_wr_rdy", 78'(wr_rdy), 78'(0));
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      @(negedge rclk);
      if (wr_rdy) begin seen = 1; break; end
    end
    chk("full_release", 78'(seen), 78'(1));
    cyc(); wr_req = 1'b0; rd_req = 1'b0;
    cyc(); cyc(); cyc();
    @(negedge rclk);
    chk("full_drained", 78'(wbuf_cnt), 78'(0));

    // Half write, same-cycle enqueue+drain, and wen=00 discard
    cyc(); wr_req = 1'b1; wr_addr = 7'h20; wr_wen = 2'b11; wr_data = 78'd0;
    cyc(); wr_wen = 2'b01; wr_data = {78{1'b1}};
    cyc(); wr_req = 1'b0;
    @(negedge rclk);
    chk("enq_drain_cnt", 78'(wbuf_cnt), 78'(1));
    cyc(); wr_req = 1'b1; wr_wen = 2'b00; wr_data = 78'h1_2345;
    @(negedge rclk);
    chk("wen0_wr_rdy", 78'(wr_rdy), 78'(1));
    cyc(); wr_req = 1'b0;
    @(negedge rclk);
    chk("wen0_no_enq", 78'(wbuf_cnt), 78'(0));
    cyc(); rd_req = 1'b1; rd_addr = 7'h20;
    cyc(); rd_req = 1'b0;
    cyc();
    @(negedge rclk);
    chk("half_vld", 78'(rd_vld), 78'(1));
    chk("half_data", rd_data, 78'h7F_FFFF_FFFF);

    // Reset while a read is in flight and a write is buffered
    cyc(); rd_req = 1'b1; rd_addr = 7'h05;
    wr_req = 1'b1; wr_addr = 7'h60; wr_wen = 2'b11; wr_data = 78'h60;
    cyc(); rd_req = 1'b0; wr_req = 1'b0; reset = 1'b1;
    seen = 0;
    @(negedge rclk);
    if (rd_vld) seen = 1;
    cyc(); reset = 1'b0;
    @(negedge rclk);
    if (rd_vld) seen = 1;
    chk("midrst_cnt", 78'(wbuf_cnt), 78'(0));
    cyc();
    @(negedge rclk);
    if (rd_vld) seen = 1;
    chk("midrst_no_vld", 78'(seen), 78'(0));

    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
